// File: rtl/apb_bus_bridge.sv
// -----------------------------------------------------------------------------
// apb_bus_bridge
//   Registered N-slot APB-style transfer engine between the core data port and
//   the memory-mapped peripherals. Each slot owns a 2^SLOT_BITS-byte window
//   above BASE_ADDR. A transfer runs IDLE -> SETUP -> ACCESS (wait states via
//   pready, bounded by a TIMEOUT watchdog) -> RESP. Unmapped addresses go
//   straight from IDLE to an error RESP without touching psel.
//
//   Optional feature: define BRIDGE_ERRLOG_EN to build the error log
//   (err_addr = address of the last error response, err_cnt = saturating
//   count of error responses). Without it both outputs are tied to 0.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   req/addr/we/wdata/bhw : core transfer request and attributes
//   rdata/ready/err     : registered read data, 1-cycle done pulse, error flag
//   psel/penable        : one-hot slot select, access phase
//   pwrite/paddr/pwdata/pbhw : latched transfer attributes
//   prdata/pready       : per-slot read data (32 bits per slot) and ready
//   err_addr/err_cnt    : error log
// -----------------------------------------------------------------------------
module apb_bus_bridge #(
    parameter int          NUM_SLV   = 10,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter int          SLOT_BITS = 8,
    parameter int          TIMEOUT   = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req,
    input  logic [31:0]           addr,
    input  logic                  we,
    input  logic [31:0]           wdata,
    input  logic [1:0]            bhw,
    output logic [31:0]           rdata,
    output logic                  ready,
    output logic                  err,
    output logic [NUM_SLV-1:0]    psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           paddr,
    output logic [31:0]           pwdata,
    output logic [1:0]            pbhw,
    input  logic [NUM_SLV*32-1:0] prdata,
    input  logic [NUM_SLV-1:0]    pready,
    output logic [31:0]           err_addr,
    output logic [7:0]            err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg;
    logic [31:0] addr_reg;
    logic        we_reg;
    logic [31:0] wdata_reg;
    logic [1:0]  bhw_reg;
    logic        err_flag_reg;
    logic [9:0]  wait_cnt_reg;
    logic [31:0] rdata_reg;

    // Address decode (32-bit unsigned; below-base wraps and is rejected by
    // the explicit >= test).
    logic [31:0] off;
    logic [31:0] idx_full;
    logic        hit;
    assign off      = addr - BASE_ADDR;
    assign idx_full = off >> SLOT_BITS;
    assign hit      = (addr >= BASE_ADDR) && (idx_full < 32'(NUM_SLV));

    // Selected-slot ready/read data. Masking with psel makes unselected
    // slots invisible without indexing by a possibly out-of-range idx.
    logic              sel_active;
    logic [NUM_SLV-1:0] rdy_masked;
    logic [31:0]        rd_masked [NUM_SLV];
    logic               sel_ready;
    logic [31:0]        sel_rdata;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLV; gi++) begin : g_slot
            assign psel[gi]       = sel_active && (idx_reg == 4'(gi));
            assign rdy_masked[gi] = psel[gi] & pready[gi];
            assign rd_masked[gi]  = psel[gi] ? prdata[32*gi +: 32] : 32'd0;
        end
    endgenerate

    always_comb begin
        sel_rdata = 32'd0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_rdata = sel_rdata | rd_masked[i];
        end
        sel_ready = |rdy_masked;
    end

    // Fires on the TIMEOUT-th ACCESS cycle; sel_ready is checked first so a
    // late pready still completes successfully.
    logic timeout_hit;
    assign timeout_hit = (wait_cnt_reg == 10'(TIMEOUT - 1));

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // FSM: next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (req) state_next = hit ? ST_SETUP : ST_RESP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (sel_ready || timeout_hit) state_next = ST_RESP;
            ST_RESP:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        sel_active = (state_reg == ST_SETUP) || (state_reg == ST_ACCESS);
        penable    = (state_reg == ST_ACCESS);
        ready      = (state_reg == ST_RESP);
        err        = (state_reg == ST_RESP) && err_flag_reg;
    end

    // Datapath: attribute latch, wait counter, response data
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_reg      <= '0;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
            wdata_reg    <= '0;
            bhw_reg      <= '0;
            err_flag_reg <= 1'b0;
            wait_cnt_reg <= '0;
            rdata_reg    <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    wait_cnt_reg <= '0;
                    if (req) begin
                        idx_reg      <= idx_full[3:0];
                        addr_reg     <= addr;
                        we_reg       <= we;
                        wdata_reg    <= wdata;
                        bhw_reg      <= bhw;
                        err_flag_reg <= !hit;
                        if (!hit) rdata_reg <= '0;
                    end
                end
                ST_SETUP: wait_cnt_reg <= '0;
                ST_ACCESS: begin
                    if (sel_ready) begin
                        rdata_reg    <= we_reg ? 32'd0 : sel_rdata;
                        err_flag_reg <= 1'b0;
                    end else if (timeout_hit) begin
                        rdata_reg    <= '0;
                        err_flag_reg <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rdata  = rdata_reg;
    assign paddr  = addr_reg;
    assign pwrite = we_reg;
    assign pwdata = wdata_reg;
    assign pbhw   = bhw_reg;

`ifdef BRIDGE_ERRLOG_EN
    // Log is loaded on the edge that enters an error RESP so it is already
    // visible while ready/err are high.
    logic [31:0] err_addr_reg;
    logic [7:0]  err_cnt_reg;
    logic        log_en;
    logic [31:0] log_addr;

    always_comb begin
        log_en   = 1'b0;
        log_addr = addr_reg;
        if (state_reg == ST_IDLE && req && !hit) begin
            log_en   = 1'b1;
            log_addr = addr;
        end else if (state_reg == ST_ACCESS && !sel_ready && timeout_hit) begin
            log_en   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr_reg <= '0;
            err_cnt_reg  <= '0;
        end else if (log_en) begin
            err_addr_reg <= log_addr;
            if (err_cnt_reg != 8'hFF) err_cnt_reg <= err_cnt_reg + 8'd1;
        end
    end

    assign err_addr = err_addr_reg;
    assign err_cnt  = err_cnt_reg;
`else
    assign err_addr = 32'd0;
    assign err_cnt  = 8'd0;
`endif

endmodule

// File: tb/tb_apb_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_apb_bus_bridge
//   Directed bench for apb_bus_bridge (NUM_SLV=10, TIMEOUT=8). Inputs are
//   driven 1 time unit after the rising edge and outputs sampled there too,
//   so "cycle k" below means the cycle following edge k of a transfer.
// -----------------------------------------------------------------------------
module tb_apb_bus_bridge;

    localparam int NS = 10;

    logic            clk = 1'b0;
    logic            reset;
    logic            req;
    logic [31:0]     addr;
    logic            we;
    logic [31:0]     wdata;
    logic [1:0]      bhw;
    logic [31:0]     rdata;
    logic            ready;
    logic            err;
    logic [NS-1:0]   psel;
    logic            penable;
    logic            pwrite;
    logic [31:0]     paddr;
    logic [31:0]     pwdata;
    logic [1:0]      pbhw;
    logic [NS*32-1:0] prdata;
    logic [NS-1:0]   pready;
    logic [31:0]     err_addr;
    logic [7:0]      err_cnt;

    int total = 0;
    int bad   = 0;
    int errlog_on;

    apb_bus_bridge #(
        .NUM_SLV   (NS),
        .BASE_ADDR (32'h4000_0000),
        .SLOT_BITS (8),
        .TIMEOUT   (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .addr     (addr),
        .we       (we),
        .wdata    (wdata),
        .bhw      (bhw),
        .rdata    (rdata),
        .ready    (ready),
        .err      (err),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pbhw     (pbhw),
        .prdata   (prdata),
        .pready   (pready),
        .err_addr (err_addr),
        .err_cnt  (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [1:0] s);
        req = 1'b1; addr = a; we = w; wdata = d; bhw = s;
    endtask

    initial begin
`ifdef BRIDGE_ERRLOG_EN
        errlog_on = 1;
`else
        errlog_on = 0;
`endif
        reset = 1'b1; req = 1'b0; addr = '0; we = 1'b0; wdata = '0; bhw = '0;
        prdata = '0; pready = '0;
        tick(); tick();
        check("rst_psel",    32'(psel), 32'h0);
        check("rst_penable", 32'(penable), 32'h0);
        check("rst_ready",   32'(ready), 32'h0);
        check("rst_rdata",   rdata, 32'h0);
        check("rst_errcnt",  32'(err_cnt), 32'h0);
        reset = 1'b0;
        tick();

        // Zero-wait read, slot 3
        prdata[32*3 +: 32] = 32'hDEAD_BEEF;
        prdata[32*9 +: 32] = 32'h0909_0909;
        pready = '1;
        start(32'h4000_0304, 1'b0, 32'h0, 2'd2);
        tick();
        check("zw_c1_psel",    32'(psel), 32'h008);
        check("zw_c1_penable", 32'(penable), 32'h0);
        tick();
        check("zw_c2_psel",    32'(psel), 32'h008);
        check("zw_c2_penable", 32'(penable), 32'h1);
        check("zw_c2_ready",   32'(ready), 32'h0);
        tick();
        check("zw_c3_ready", 32'(ready), 32'h1);
        check("zw_c3_err",   32'(err), 32'h0);
        check("zw_c3_rdata", rdata, 32'hDEAD_BEEF);
        req = 1'b0;
        tick();
        check("zw_c4_ready", 32'(ready), 32'h0);
        $display("txn zero-wait read slot3 rdata=%08h", rdata);

        // Write with 4 wait states, slot 0 (other slots ready but ignored)
        pready = 10'h3FE;
        start(32'h4000_0000, 1'b1, 32'h1234_5678, 2'd2);
        tick();
        check("wr_c1_psel",   32'(psel), 32'h001);
        check("wr_c1_pwrite", 32'(pwrite), 32'h1);
        check("wr_c1_pbhw",   32'(pbhw), 32'h2);
        check("wr_c1_paddr",  paddr, 32'h4000_0000);
        for (int c = 2; c <= 6; c++) begin
            tick();
            check("wr_acc_penable", 32'(penable), 32'h1);
            check("wr_acc_pwdata",  pwdata, 32'h1234_5678);
            check("wr_acc_ready",   32'(ready), 32'h0);
            if (c == 6) pready[0] = 1'b1;
        end
        tick();
        check("wr_c7_ready", 32'(ready), 32'h1);
        check("wr_c7_err",   32'(err), 32'h0);
        check("wr_c7_rdata", rdata, 32'h0);
        req = 1'b0; we = 1'b0;
        tick();
        $display("txn write slot0 with 4 waits");

        // Highest slot (9) zero-wait read
        pready = '1;
        start(32'h4000_09FC, 1'b0, 32'h0, 2'd2);
        tick();
        check("s9_psel", 32'(psel), 32'h200);
        tick(); tick();
        check("s9_ready", 32'(ready), 32'h1);
        check("s9_rdata", rdata, 32'h0909_0909);
        req = 1'b0;
        tick();
        $display("txn read slot9");

        // Miss above last slot (idx 10)
        start(32'h4000_0A00, 1'b0, 32'h0, 2'd2);
        tick();
        check("miss_ready", 32'(ready), 32'h1);
        check("miss_err",   32'(err), 32'h1);
        check("miss_rdata", rdata, 32'h0);
        check("miss_psel",  32'(psel), 32'h0);
        check("miss_eaddr", err_addr, errlog_on != 0 ? 32'h4000_0A00 : 32'h0);
        check("miss_ecnt",  32'(err_cnt), errlog_on != 0 ? 32'h1 : 32'h0);
        req = 1'b0;
        tick();
        $display("txn miss idx10");

        // Miss below base (write: must not raise psel)
        start(32'h3FFF_FFFC, 1'b1, 32'hFFFF_FFFF, 2'd2);
        tick();
        check("low_err",  32'(err), 32'h1);
        check("low_psel", 32'(psel), 32'h0);
        check("low_ecnt", 32'(err_cnt), errlog_on != 0 ? 32'h2 : 32'h0);
        req = 1'b0; we = 1'b0;
        tick();
        $display("txn miss below base");

        // Timeout on slot 5, then back-to-back request completes
        pready = 10'h3DF;
        prdata[32*5 +: 32] = 32'h55AA_0005;
        start(32'h4000_0500, 1'b0, 32'h0, 2'd2);
        for (int c = 1; c <= 9; c++) begin
            tick();
            check("to_wait_ready", 32'(ready), 32'h0);
        end
        tick();
        check("to_c10_ready", 32'(ready), 32'h1);
        check("to_c10_err",   32'(err), 32'h1);
        check("to_c10_rdata", rdata, 32'h0);
        check("to_eaddr", err_addr, errlog_on != 0 ? 32'h4000_0500 : 32'h0);
        check("to_ecnt",  32'(err_cnt), errlog_on != 0 ? 32'h3 : 32'h0);
        pready[5] = 1'b1;
        tick();
        check("b2b_c11_psel",  32'(psel), 32'h0);
        check("b2b_c11_ready", 32'(ready), 32'h0);
        tick();
        check("b2b_c12_psel",    32'(psel), 32'h020);
        check("b2b_c12_penable", 32'(penable), 32'h0);
        tick(); tick();
        check("b2b_ready", 32'(ready), 32'h1);
        check("b2b_err",   32'(err), 32'h0);
        check("b2b_rdata", rdata, 32'h55AA_0005);
        req = 1'b0;
        tick();
        $display("txn timeout slot5 then back-to-back read");

        // pready arrives on the cycle the timeout would fire: success wins
        pready[5] = 1'b0;
        prdata[32*5 +: 32] = 32'h0000_5A5A;
        start(32'h4000_0500, 1'b0, 32'h0, 2'd2);
        for (int c = 1; c <= 9; c++) begin
            tick();
            check("race_wait_ready", 32'(ready), 32'h0);
            if (c == 9) pready[5] = 1'b1;
        end
        tick();
        check("race_ready", 32'(ready), 32'h1);
        check("race_err",   32'(err), 32'h0);
        check("race_rdata", rdata, 32'h0000_5A5A);
        req = 1'b0;
        tick();
        $display("txn late pready at timeout boundary");

        // Reset during a stalled ACCESS, then a normal hit
        pready = 10'h3FB;
        prdata[32*2 +: 32] = 32'hC0FF_EE02;
        start(32'h4000_0208, 1'b1, 32'hA5A5_A5A5, 2'd1);
        tick(); tick(); tick();
        check("ra_penable", 32'(penable), 32'h1);
        reset = 1'b1;
        tick();
        check("ra_psel",    32'(psel), 32'h0);
        check("ra_penable0", 32'(penable), 32'h0);
        check("ra_pwrite",  32'(pwrite), 32'h0);
        check("ra_paddr",   paddr, 32'h0);
        check("ra_pwdata",  pwdata, 32'h0);
        check("ra_pbhw",    32'(pbhw), 32'h0);
        check("ra_ready",   32'(ready), 32'h0);
        check("ra_err",     32'(err), 32'h0);
        check("ra_rdata",   rdata, 32'h0);
        check("ra_eaddr",   err_addr, 32'h0);
        check("ra_ecnt",    32'(err_cnt), 32'h0);
        reset = 1'b0; we = 1'b0; pready[2] = 1'b1;
        tick();
        check("ra_c1_psel", 32'(psel), 32'h004);
        tick();
        check("ra_c2_ready", 32'(ready), 32'h0);
        tick();
        check("ra_c3_ready", 32'(ready), 32'h1);
        check("ra_c3_rdata", rdata, 32'hC0FF_EE02);
        req = 1'b0;
        tick();
        $display("txn reset in access then read slot2");

        // 260 back-to-back misses: log saturates
        begin
            int n;
            n = 0;
            start(32'h5000_0000, 1'b0, 32'h0, 2'd2);
            for (int i = 0; i < 260; i++) begin
                tick();
                if (ready && err) n++;
                tick();
            end
            req = 1'b0;
            tick();
            check("sat_resps", 32'(n), 32'd260);
            check("sat_ecnt",  32'(err_cnt), errlog_on != 0 ? 32'd255 : 32'd0);
            check("sat_eaddr", err_addr, errlog_on != 0 ? 32'h5000_0000 : 32'h0);
            $display("txn 260 misses err_cnt=%0d", err_cnt);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
